// File: rtl/isp_boot_controller_if.sv
// Host byte stream in, program-memory write port out.
// master: boot controller side; slave: host link / memory side.
interface isp_boot_controller_if #(
  parameter int ADDRESS_BITS = 12,
  parameter int DATA_WIDTH   = 32
);
  logic [7:0]              rx_data;
  logic                    rx_valid;
  logic                    rx_ready;
  logic                    isp_write;
  logic [ADDRESS_BITS-1:0] isp_address;
  logic [DATA_WIDTH-1:0]   isp_data;

  modport master (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    output isp_write,
    output isp_address,
    output isp_data
  );

  modport slave (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    input  isp_write,
    input  isp_address,
    input  isp_data
  );
endinterface

// File: rtl/isp_boot_controller.sv
// Unpacks a length-prefixed image into program memory while holding
// the core in reset, then releases it and pulses start at the entry PC.
module isp_boot_controller #(
  parameter int ADDRESS_BITS = 12,
  parameter int DATA_WIDTH   = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        load_req,
  isp_boot_controller_if.master bus,
  output logic        core_reset,
  output logic        start,
  output logic [19:0] prog_address,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] DEPTH = 32'd1 << ADDRESS_BITS;
  localparam logic [ADDRESS_BITS:0] IDX_ONE = {{ADDRESS_BITS{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_ENTRY,
    S_DATA,
    S_LAUNCH,
    S_RUN,
    S_ERROR
  } state_t;

  state_t state_q, state_d;

  logic [1:0]              byte_q, byte_d;
  logic [ADDRESS_BITS:0]   idx_q, idx_d;
  logic [ADDRESS_BITS:0]   total_q, total_d;
  logic [7:0]              n_lo_q, n_lo_d;
  logic [23:0]             pc_q, pc_d;
  logic [23:0]             asm_q, asm_d;

  logic                    core_reset_q, core_reset_d;
  logic                    start_q, start_d;
  logic                    isp_write_q, isp_write_d;
  logic [ADDRESS_BITS-1:0] isp_address_q, isp_address_d;
  logic [DATA_WIDTH-1:0]   isp_data_q, isp_data_d;
  logic [19:0]             prog_address_q, prog_address_d;

  logic                    rx_ready;
  logic                    take;
  logic [15:0]             n_full;
  logic [31:0]             pc_full;
  logic [31:0]             word;
  logic                    n_ok;
  logic [ADDRESS_BITS:0]   idx_last;

  assign rx_ready = (state_q == S_COUNT) ||
                    (state_q == S_ENTRY) ||
                    (state_q == S_DATA);
  assign take     = rx_ready && bus.rx_valid;

  assign busy  = rx_ready || (state_q == S_LAUNCH);
  assign done  = (state_q == S_RUN);
  assign error = (state_q == S_ERROR);

  assign bus.rx_ready    = rx_ready;
  assign bus.isp_write   = isp_write_q;
  assign bus.isp_address = isp_address_q;
  assign bus.isp_data    = isp_data_q;

  assign core_reset   = core_reset_q;
  assign start        = start_q;
  assign prog_address = prog_address_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      byte_q         <= '0;
      idx_q          <= '0;
      total_q        <= '0;
      n_lo_q         <= '0;
      pc_q           <= '0;
      asm_q          <= '0;
      core_reset_q   <= 1'b1;
      start_q        <= 1'b0;
      isp_write_q    <= 1'b0;
      isp_address_q  <= '0;
      isp_data_q     <= '0;
      prog_address_q <= '0;
    end else begin
      state_q        <= state_d;
      byte_q         <= byte_d;
      idx_q          <= idx_d;
      total_q        <= total_d;
      n_lo_q         <= n_lo_d;
      pc_q           <= pc_d;
      asm_q          <= asm_d;
      core_reset_q   <= core_reset_d;
      start_q        <= start_d;
      isp_write_q    <= isp_write_d;
      isp_address_q  <= isp_address_d;
      isp_data_q     <= isp_data_d;
      prog_address_q <= prog_address_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    byte_d         = byte_q;
    idx_d          = idx_q;
    total_d        = total_q;
    n_lo_d         = n_lo_q;
    pc_d           = pc_q;
    asm_d          = asm_q;
    core_reset_d   = core_reset_q;
    start_d        = 1'b0;
    isp_write_d    = 1'b0;
    isp_address_d  = isp_address_q;
    isp_data_d     = isp_data_q;
    prog_address_d = prog_address_q;

    // Final byte of each field completes the value with the live rx byte.
    n_full   = {bus.rx_data, n_lo_q};
    pc_full  = {bus.rx_data, pc_q};
    word     = {bus.rx_data, asm_q};
    n_ok     = (n_full != 16'd0) && ({16'd0, n_full} <= DEPTH);
    idx_last = total_q - IDX_ONE;

    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (load_req) begin
          state_d      = S_COUNT;
          byte_d       = '0;
          idx_d        = '0;
          core_reset_d = 1'b1;
        end
      end
      S_COUNT: begin
        if (take) begin
          if (byte_q == 2'd0) begin
            n_lo_d = bus.rx_data;
            byte_d = 2'd1;
          end else begin
            byte_d = 2'd0;
            if (n_ok) begin
              total_d = n_full[ADDRESS_BITS:0];
              state_d = S_ENTRY;
            end else begin
              state_d = S_ERROR;
            end
          end
        end
      end
      S_ENTRY: begin
        if (take) begin
          byte_d = byte_q + 2'd1;
          if (byte_q != 2'd3) begin
            pc_d[{byte_q, 3'b000} +: 8] = bus.rx_data;
          end else if (pc_full[1:0] != 2'b00) begin
            state_d = S_ERROR;
          end else begin
            prog_address_d = pc_full[19:0];
            state_d        = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (take) begin
          byte_d = byte_q + 2'd1;
          if (byte_q != 2'd3) begin
            asm_d[{byte_q, 3'b000} +: 8] = bus.rx_data;
          end else begin
            isp_data_d    = word;
            isp_address_d = idx_q[ADDRESS_BITS-1:0];
            isp_write_d   = 1'b1;
            idx_d         = idx_q + IDX_ONE;
            if (idx_q == idx_last) begin
              state_d = S_LAUNCH;
            end
          end
        end
      end
      S_LAUNCH: begin
        state_d      = S_RUN;
        start_d      = 1'b1;
        core_reset_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule
